// File: rtl/screen_sequencer.sv
// Battle Tank screen controller: title/fade/play/over sequencing and a
// registered 12-bit RGB source select feeding the VGA output register.
module screen_sequencer #(
  parameter int unsigned HOLD_FRAMES      = 120,
  parameter int unsigned FADE_STEP_FRAMES = 8
) (
  input  logic        pClk,
  input  logic        pReset,
  input  logic        pStart,
  input  logic        pGame_over,
  input  logic        pFrame_start,
  input  logic        pVideo_on,
  input  logic [11:0] pFirst_in,
  input  logic [11:0] pGame_in,
  input  logic [11:0] pOver_in,
  output logic [11:0] pScreen_out,
  output logic [1:0]  pState,
  output logic        pGame_enable,
  output logic        pGame_reset
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned RGB_W = 12;
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] FADE_LAST = CNT_W'(FADE_STEP_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_TITLE = 2'd0,
    ST_FADE  = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         level_q, level_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic               pend_q, pend_d;
  logic               sync1_q, sync2_q, prev_q;
  logic [RGB_W-1:0]   screen_q, screen_d;
  logic               en_q, en_d;
  logic               grst_q, grst_d;
  logic               edge_c, accept_c, pend_c, hold_full_c;

  function automatic logic [RGB_W-1:0] dim(input logic [RGB_W-1:0] rgb,
                                           input logic [1:0] sh);
    return {rgb[11:8] >> sh, rgb[7:4] >> sh, rgb[3:0] >> sh};
  endfunction

  // Next-state, counters, start-pending and pixel capture.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    fcnt_d   = fcnt_q;
    hold_d   = hold_q;
    screen_d = '0;

    edge_c      = sync2_q & ~prev_q;
    hold_full_c = (hold_q == HOLD_MAX);
    // Start is only accepted in TITLE, or in OVER once the hold time has elapsed.
    accept_c    = edge_c & ((state_q == ST_TITLE) |
                            ((state_q == ST_OVER) & hold_full_c));
    pend_c      = pend_q | accept_c;

    if (pFrame_start) begin
      case (state_q)
        ST_TITLE: begin
          if (pend_c) begin
            state_d = ST_FADE;
            level_d = 2'd0;
            fcnt_d  = '0;
          end
        end
        ST_FADE: begin
          if (fcnt_q == FADE_LAST) begin
            fcnt_d = '0;
            if (level_q == 2'd3) state_d = ST_PLAY;
            else                 level_d = level_q + 2'd1;
          end else begin
            fcnt_d = fcnt_q + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          if (pGame_over) begin
            state_d = ST_OVER;
            hold_d  = '0;
          end
        end
        default: begin
          if (hold_full_c && pend_c) state_d = ST_TITLE;
          else if (!hold_full_c)     hold_d  = hold_q + CNT_W'(1);
        end
      endcase
    end

    if ((state_d != state_q) || (state_q == ST_FADE) || (state_q == ST_PLAY))
      pend_d = 1'b0;
    else
      pend_d = pend_c;

    // Source follows the pre-transition state; first pixel of a frame is blanked anyway.
    if (pVideo_on) begin
      case (state_q)
        ST_TITLE: screen_d = pFirst_in;
        ST_FADE:  screen_d = dim(pFirst_in, level_q);
        ST_PLAY:  screen_d = pGame_in;
        default:  screen_d = pOver_in;
      endcase
    end

    en_d   = (state_d == ST_PLAY);
    grst_d = ~en_d;
  end

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      state_q  <= ST_TITLE;
      level_q  <= 2'd0;
      fcnt_q   <= '0;
      hold_q   <= '0;
      pend_q   <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      screen_q <= '0;
      en_q     <= 1'b0;
      grst_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      fcnt_q   <= fcnt_d;
      hold_q   <= hold_d;
      pend_q   <= pend_d;
      sync1_q  <= pStart;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      screen_q <= screen_d;
      en_q     <= en_d;
      grst_q   <= grst_d;
    end
  end

  assign pScreen_out  = screen_q;
  assign pState       = state_q;
  assign pGame_enable = en_q;
  assign pGame_reset  = grst_q;

endmodule
